mem_access_unit: RTL

- Memory-stage load/store unit between execute and writeback.
- Takes one instruction plus its effective address and store data, and drives a req/gnt/rvalid data-memory handshake.
- Formats load data with sign/zero extension into the 32-bit DDT value that writeback consumes.
- Holds one instruction at a time and stalls upstream while a memory transaction is outstanding.

---
 rtl/mem_access_unit.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: one instruction at a time, req/gnt/rvalid data-memory
// handshake, load formatting into DDT. Optional misalignment trap: MEM_ACCESS_MISALIGN_TRAP_EN.
module mem_access_unit #(
    parameter int unsigned TIMEOUT   = 16,
    parameter logic [31:0] RESET_DDT = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] inst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        done,
    output logic [31:0] DDT,
    output logic        err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam int         CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT - 1);

    // funct3[1:0]: 00 byte, 01 halfword, 1x word (covers LW aliases)
    function automatic logic [3:0] calc_be(input logic [2:0] f3, input logic [1:0] o);
        logic [3:0] be;
        case (f3[1:0])
            2'b00:   be = 4'b0001 << o;
            2'b01:   be = 4'b0011 << {o[1], 1'b0};
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] calc_wdata(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] w;
        case (f3[1:0])
            2'b00:   w = {4{d[7:0]}};
            2'b01:   w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] o,
                                             input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (o)
            2'b00:   b = d[7:0];
            2'b01:   b = d[15:8];
            2'b10:   b = d[23:16];
            2'b11:   b = d[31:24];
            default: b = d[7:0];
        endcase
        h = o[1] ? d[31:16] : d[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b100:  r = {24'h00_0000, b};
            3'b101:  r = {16'h0000, h};
            default: r = d;
        endcase
        return r;
    endfunction

    state_t            state_r;
    state_t            state_nxt_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_nxt_s;
    logic              in_ready_r;
    logic              mem_req_r;
    logic              mem_we_r;
    logic [31:0]       mem_addr_r;
    logic [3:0]        mem_be_r;
    logic [31:0]       mem_wdata_r;
    logic              done_r;
    logic              done_nxt_s;
    logic              err_r;
    logic              err_nxt_s;
    logic [31:0]       ddt_r;
    logic [31:0]       ddt_nxt_s;
    logic [2:0]        f3_r;
    logic [1:0]        off_r;
    logic              is_load_r;
    logic              launch_s;
    logic              is_load_s;
    logic              is_store_s;
    logic              is_mem_s;
    logic              misalign_s;
    logic              unused_s;

    assign is_load_s  = (inst[6:0] == OP_LOAD);
    assign is_store_s = (inst[6:0] == OP_STORE);
    assign is_mem_s   = is_load_s | is_store_s;
    assign unused_s   = ^{inst[31:15], inst[11:7]};

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    assign misalign_s = is_mem_s &&
                        (((inst[13:12] == 2'b01) && addr[0]) ||
                         (inst[13] && (addr[1:0] != 2'b00)));
`else
    assign misalign_s = 1'b0;
`endif

    // Next-state, timeout counter and completion values
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        done_nxt_s  = 1'b0;
        err_nxt_s   = 1'b0;
        ddt_nxt_s   = ddt_r;
        launch_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (in_valid && in_ready_r) begin
                    if (is_mem_s && !misalign_s) begin
                        state_nxt_s = ST_REQ;
                        launch_s    = 1'b1;
                    end else begin
                        state_nxt_s = ST_DONE;
                        done_nxt_s  = 1'b1;
                        err_nxt_s   = misalign_s;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mem_gnt) begin
                    state_nxt_s = ST_WAIT;
                    cnt_nxt_s   = '0;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                // A response arriving on the limit cycle still completes normally
                if (mem_rvalid) begin
                    state_nxt_s = ST_DONE;
                    done_nxt_s  = 1'b1;
                    if (is_load_r) begin
                        ddt_nxt_s = fmt_load(f3_r, off_r, mem_rdata);
                    end else begin
                        ddt_nxt_s = ddt_r;
                    end
                end else if (cnt_r == CNT_LIM) begin
                    state_nxt_s = ST_DONE;
                    done_nxt_s  = 1'b1;
                    err_nxt_s   = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register and registered handshake/result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= '0;
            in_ready_r  <= 1'b0;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= 32'h0000_0000;
            mem_be_r    <= 4'b0000;
            mem_wdata_r <= 32'h0000_0000;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            ddt_r       <= RESET_DDT;
            f3_r        <= 3'b000;
            off_r       <= 2'b00;
            is_load_r   <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            cnt_r      <= cnt_nxt_s;
            in_ready_r <= (state_nxt_s == ST_IDLE);
            mem_req_r  <= (state_nxt_s == ST_REQ);
            done_r     <= done_nxt_s;
            err_r      <= err_nxt_s;
            ddt_r      <= ddt_nxt_s;
            if (launch_s) begin
                mem_we_r    <= is_store_s;
                mem_addr_r  <= {addr[31:2], 2'b00};
                mem_be_r    <= calc_be(inst[14:12], addr[1:0]);
                mem_wdata_r <= calc_wdata(inst[14:12], wdata);
                f3_r        <= inst[14:12];
                off_r       <= addr[1:0];
                is_load_r   <= is_load_s;
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_be    = mem_be_r;
    assign mem_wdata = mem_wdata_r;
    assign done      = done_r;
    assign err       = err_r;
    assign DDT       = ddt_r;

endmodule
